// File: rtl/shared_adder_arbiter.sv
// ----------------------------------------------------------------------------
// shared_adder_arbiter
//
// Purpose:
//   Two requesters share one 16-bit carry-lookahead adder. A round-robin
//   arbiter grants one request in IDLE. The operands are registered and
//   evaluated in EXEC. The result is presented in RESP until the consumer
//   takes it. Each operation is either A + B or A - B (A + ~B + 1).
//
// Optional feature:
//   SHARED_ADDER_SAT_EN - when defined, an overflowing result is replaced
//   by the saturated value: 16'h7FFF for a non-negative A, 16'h8000 for a
//   negative A. rsp_ovfl still reports the overflow.
//
// Ports:
//   clk                  clock, all state updates on the rising edge
//   rst                  asynchronous active-high reset
//   req_valid[1:0]       per-requester request valid
//   req_ready[1:0]       per-requester accept (combinational in IDLE)
//   req_a0/req_b0        requester 0 operands
//   req_a1/req_b1        requester 1 operands
//   req_sub[1:0]         1 = subtract for that requester, 0 = add
//   rsp_valid            result register holds an unconsumed result
//   rsp_ready            consumer accepts the result
//   rsp_sum[15:0]        result value
//   rsp_ovfl             signed overflow of the operation
//   rsp_id               requester that issued the result
// ----------------------------------------------------------------------------
module shared_adder_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_a0,
    input  logic [15:0] req_b0,
    input  logic [15:0] req_a1,
    input  logic [15:0] req_b1,
    input  logic [1:0]  req_sub,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_sum,
    output logic        rsp_ovfl,
    output logic        rsp_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic        op_sub_q, op_sub_d;
    logic        op_id_q, op_id_d;
    logic [15:0] sum_q, sum_d;
    logic        ovfl_q, ovfl_d;
    logic        id_q, id_d;
    logic        rsp_valid_q, rsp_valid_d;

    logic [1:0]  grant;

    // ------------------------------------------------------------------
    // Shared carry-lookahead adder: four 4-bit groups with a second-level
    // lookahead for the group carries. Only the operand registers feed it.
    // ------------------------------------------------------------------
    logic [15:0] b_eff;
    logic [15:0] bit_g;
    logic [15:0] bit_p;
    logic [15:0] bit_c;
    logic [15:0] cla_sum;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [3:0]  grp_c;
    logic        cla_ovfl;
    logic [15:0] result_val;

    assign b_eff = op_sub_q ? ~op_b_q : op_b_q;
    assign bit_g = op_a_q & b_eff;
    assign bit_p = op_a_q ^ b_eff;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_grp
            localparam int B = 4 * gi;
            assign grp_p[gi] = &bit_p[B +: 4];
            assign grp_g[gi] = bit_g[B+3]
                             | (bit_p[B+3] & bit_g[B+2])
                             | (bit_p[B+3] & bit_p[B+2] & bit_g[B+1])
                             | (bit_p[B+3] & bit_p[B+2] & bit_p[B+1] & bit_g[B]);
            assign bit_c[B]   = grp_c[gi];
            assign bit_c[B+1] = bit_g[B] | (bit_p[B] & grp_c[gi]);
            assign bit_c[B+2] = bit_g[B+1]
                              | (bit_p[B+1] & bit_g[B])
                              | (bit_p[B+1] & bit_p[B] & grp_c[gi]);
            assign bit_c[B+3] = bit_g[B+2]
                              | (bit_p[B+2] & bit_g[B+1])
                              | (bit_p[B+2] & bit_p[B+1] & bit_g[B])
                              | (bit_p[B+2] & bit_p[B+1] & bit_p[B] & grp_c[gi]);
        end
    endgenerate

    // Group carries are expanded directly from the carry-in (= op_sub_q)
    // so no group carry depends on another one.
    assign grp_c[0] = op_sub_q;
    assign grp_c[1] = grp_g[0] | (grp_p[0] & op_sub_q);
    assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0])
                    | (grp_p[1] & grp_p[0] & op_sub_q);
    assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1])
                    | (grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[2] & grp_p[1] & grp_p[0] & op_sub_q);

    assign cla_sum  = bit_p ^ bit_c;
    assign cla_ovfl = (op_a_q[15] == b_eff[15]) && (cla_sum[15] != op_a_q[15]);

`ifdef SHARED_ADDER_SAT_EN
    assign result_val = !cla_ovfl   ? cla_sum :
                        op_a_q[15]  ? 16'h8000 : 16'h7FFF;
`else
    assign result_val = cla_sum;
`endif

    // ------------------------------------------------------------------
    // Round-robin grant. Only meaningful in IDLE; held off while reset
    // is asserted so every output reads 0 during reset.
    // ------------------------------------------------------------------
    always_comb begin
        grant = 2'b00;
        if ((state_q == ST_IDLE) && !rst) begin
            unique case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;

    // ------------------------------------------------------------------
    // Controller next-state and datapath loads.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_sub_d    = op_sub_q;
        op_id_d     = op_id_q;
        sum_d       = sum_q;
        ovfl_d      = ovfl_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    op_id_d  = grant[1];
                    op_a_d   = grant[1] ? req_a1 : req_a0;
                    op_b_d   = grant[1] ? req_b1 : req_b0;
                    op_sub_d = req_sub[grant[1]];
                    last_d   = grant[1];
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                sum_d       = result_val;
                ovfl_d      = cla_ovfl;
                id_d        = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            op_a_q      <= 16'h0000;
            op_b_q      <= 16'h0000;
            op_sub_q    <= 1'b0;
            op_id_q     <= 1'b0;
            sum_q       <= 16'h0000;
            ovfl_q      <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_sub_q    <= op_sub_d;
            op_id_q     <= op_id_d;
            sum_q       <= sum_d;
            ovfl_q      <= ovfl_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_ovfl  = ovfl_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// ----------------------------------------------------------------------------
// tb_shared_adder_arbiter
//
// Table-driven directed operations (contention, overflow corners,
// back-pressure), a reset-during-EXEC sequence and a randomized run, all
// compared against an arithmetic reference model of the arbiter and adder.
// ----------------------------------------------------------------------------
module tb_shared_adder_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_sub;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_sum;
    logic        rsp_ovfl;
    logic        rsp_id;

    int n_vec;
    int n_err;

    // Reference arbiter state: the requester granted most recently.
    logic model_last;

    shared_adder_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_ovfl  (rsp_ovfl),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Round-robin rule: a lone request wins; on contention the requester
    // that did not win last time is chosen.
    function automatic logic [1:0] model_grant(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    // Exact integer arithmetic; overflow means the true result does not fit
    // a 16-bit two's-complement value.
    task automatic model_alu(input logic [15:0] a, input logic [15:0] b, input logic sub,
                             output logic [15:0] sum, output logic ovfl);
        int sa, sb, r;
        logic [31:0] rv;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sub ? (sa - sb) : (sa + sb);
        ovfl = (r > 32767) || (r < -32768);
        rv  = r;
        sum = rv[15:0];
`ifdef SHARED_ADDER_SAT_EN
        if (ovfl) sum = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    endtask

    // One complete operation. Inputs change 1 time unit after a rising edge,
    // outputs are sampled on the falling edge.
    task automatic run_op(input logic [1:0] v,
                          input logic [15:0] a0, input logic [15:0] b0,
                          input logic [15:0] a1, input logic [15:0] b1,
                          input logic [1:0] sub, input int stall,
                          output logic got_id, output logic [15:0] got_sum,
                          output logic got_ovfl);
        logic [1:0]  g;
        logic        eid;
        logic [15:0] esum;
        logic        eovfl;
        got_id = 1'b0; got_sum = 16'h0; got_ovfl = 1'b0;
        @(posedge clk); #1;
        req_valid = v; req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
        req_sub = sub; rsp_ready = 1'b0;
        @(negedge clk);
        g = model_grant(v, model_last);
        chk("grant", {30'd0, req_ready}, {30'd0, g});
        if (g == 2'b00) begin
            $display("op v=%b no grant", v);
            return;
        end
        model_last = g[1];
        eid = g[1];
        if (eid) model_alu(a1, b1, sub[1], esum, eovfl);
        else     model_alu(a0, b0, sub[0], esum, eovfl);
        // EXEC: requests still asserted but must not be accepted.
        @(posedge clk); #1;
        @(negedge clk);
        chk("exec_quiet", {30'd0, req_ready, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k <= stall; k++) begin
            @(negedge clk);
            if (k == 0) begin
                got_id = rsp_id; got_sum = rsp_sum; got_ovfl = rsp_ovfl;
            end
            chk("resp", {11'd0, req_ready, rsp_valid, rsp_id, rsp_ovfl, rsp_sum},
                        {11'd0, 2'b00, 1'b1, eid, eovfl, esum});
            if (k == stall) rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        chk("released", {31'd0, rsp_valid}, 32'd0);
        $display("op v=%b id=%0d sub=%b sum=%h ovfl=%b stall=%0d",
                 v, got_id, sub, got_sum, got_ovfl, stall);
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [15:0] a0, b0, a1, b1;
        logic [1:0]  sub;
        int          stall;
        logic        exp_id;
        logic [15:0] exp_sum;
        logic        exp_ovfl;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic        gid;
        logic [15:0] gsum;
        logic        govfl;
        logic [1:0]  g;

        n_vec = 0; n_err = 0;
        model_last = 1'b1;
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0; req_sub = 2'b00;
        req_a0 = 16'h0; req_b0 = 16'h0; req_a1 = 16'h0; req_b1 = 16'h0;

        // Contention 0,1,0,1 first, then single requests and back-pressure.
        tbl[0] = '{2'b11, 16'h1234, 16'h0FF0, 16'h8000, 16'h0001, 2'b10, 0, 1'b0, 16'h2224, 1'b0};
`ifdef SHARED_ADDER_SAT_EN
        tbl[1] = '{2'b11, 16'h1234, 16'h0FF0, 16'h8000, 16'h0001, 2'b10, 0, 1'b1, 16'h8000, 1'b1};
        tbl[2] = '{2'b11, 16'h7FFF, 16'h0001, 16'h3333, 16'h1111, 2'b00, 0, 1'b0, 16'h7FFF, 1'b1};
`else
        tbl[1] = '{2'b11, 16'h1234, 16'h0FF0, 16'h8000, 16'h0001, 2'b10, 0, 1'b1, 16'h7FFF, 1'b1};
        tbl[2] = '{2'b11, 16'h7FFF, 16'h0001, 16'h3333, 16'h1111, 2'b00, 0, 1'b0, 16'h8000, 1'b1};
`endif
        tbl[3] = '{2'b11, 16'h7FFF, 16'h0001, 16'h0005, 16'h0007, 2'b10, 0, 1'b1, 16'hFFFE, 1'b0};
        tbl[4] = '{2'b01, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 2'b00, 0, 1'b0, 16'h0000, 1'b0};
`ifdef SHARED_ADDER_SAT_EN
        tbl[5] = '{2'b10, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 2'b00, 10, 1'b1, 16'h8000, 1'b1};
`else
        tbl[5] = '{2'b10, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 2'b00, 10, 1'b1, 16'h0000, 1'b1};
`endif

        // Reset state, while asserted and after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_held", {11'd0, req_ready, rsp_valid, rsp_id, rsp_ovfl, rsp_sum}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_released", {11'd0, req_ready, rsp_valid, rsp_id, rsp_ovfl, rsp_sum}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].v, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1,
                   tbl[i].sub, tbl[i].stall, gid, gsum, govfl);
            chk($sformatf("table%0d", i), {15'd0, gid, gsum, govfl},
                {15'd0, tbl[i].exp_id, tbl[i].exp_sum, tbl[i].exp_ovfl});
        end

        // Reset during EXEC: grant requester 0 (pointer now 0), then reset.
        @(posedge clk); #1;
        req_valid = 2'b01; req_a0 = 16'hAAAA; req_b0 = 16'h1111; req_sub = 2'b00;
        @(negedge clk);
        g = model_grant(2'b01, model_last);
        chk("rst_seq_grant", {30'd0, req_ready}, {30'd0, g});
        @(posedge clk); #1;
        req_valid = 2'b11;
        rst = 1'b1;
        #1;
        chk("rst_mid_exec", {11'd0, req_ready, rsp_valid, rsp_id, rsp_ovfl, rsp_sum}, 32'd0);
        model_last = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        chk("rst_no_result", {31'd0, rsp_valid}, 32'd0);
        run_op(2'b11, 16'h0102, 16'h0304, 16'h5000, 16'h5000, 2'b00, 1, gid, gsum, govfl);
        chk("rst_first_grant", {31'd0, gid}, 32'd0);
        chk("rst_first_sum", {16'd0, gsum}, {16'd0, 16'h0406});

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)),
                   16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   gid, gsum, govfl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Mutual exclusion of accepts, checked every cycle.
    always @(negedge clk) begin
        if (req_ready == 2'b11) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_onehot: got %b expected at most one bit", req_ready);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
